// File: rtl/mesh_rsc_ni.sv
// Resource-side network interface for one mesh_xy_noc node: TX FIFO + injection FSM,
// RX FIFO with overflow/misroute tracking, and packet status counters.
module mesh_rsc_ni #(
  parameter int ROW_N       = 3,
  parameter int COL_M       = 3,
  parameter int PCKT_DATA_W = 8,
  parameter int ROW_CORD    = 0,
  parameter int COL_CORD    = 0,
  parameter int TX_DEPTH_W  = 2,
  parameter int RX_DEPTH_W  = 2,
  parameter int CNT_W       = 8,
  localparam int ROW_ADDR_W = $clog2(ROW_N),
  localparam int COL_ADDR_W = $clog2(COL_M),
  localparam int PACKET_W   = PCKT_DATA_W + ROW_ADDR_W + COL_ADDR_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  input  logic [ROW_ADDR_W-1:0]  tx_dst_row_i,
  input  logic [COL_ADDR_W-1:0]  tx_dst_col_i,
  input  logic [PCKT_DATA_W-1:0] tx_data_i,
  output logic [PACKET_W-1:0]    noc_pckt_o,
  output logic                   noc_wren_o,
  input  logic                   noc_full_i,
  input  logic                   noc_ovrflw_i,
  input  logic [PACKET_W-1:0]    noc_pckt_i,
  input  logic                   noc_wren_i,
  output logic                   rx_full_o,
  output logic                   rx_ovrflw_o,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  output logic [PCKT_DATA_W-1:0] rx_data_o,
  output logic [CNT_W-1:0]       tx_cnt_o,
  output logic [CNT_W-1:0]       rx_cnt_o,
  output logic [2:0]             err_o
);
  // state | meaning
  // IDLE  | nothing injected this cycle (FIFO empty or mesh full)
  // SEND  | packet popped last cycle is on noc_pckt_o, noc_wren_o high
  typedef enum logic {IDLE, SEND} tx_state_t;

  localparam int TX_DEPTH = 1 << TX_DEPTH_W;
  localparam int RX_DEPTH = 1 << RX_DEPTH_W;
  localparam logic [TX_DEPTH_W:0]   TX_FULL_CNT = {1'b1, {TX_DEPTH_W{1'b0}}};
  localparam logic [RX_DEPTH_W:0]   RX_FULL_CNT = {1'b1, {RX_DEPTH_W{1'b0}}};
  localparam logic [ROW_ADDR_W:0]   ROW_LIM     = ROW_N[ROW_ADDR_W:0];
  localparam logic [COL_ADDR_W:0]   COL_LIM     = COL_M[COL_ADDR_W:0];
  localparam logic [ROW_ADDR_W-1:0] OWN_ROW     = ROW_CORD[ROW_ADDR_W-1:0];
  localparam logic [COL_ADDR_W-1:0] OWN_COL     = COL_CORD[COL_ADDR_W-1:0];

  // TX path
  logic [PACKET_W-1:0]   tx_mem [TX_DEPTH];
  logic [TX_DEPTH_W-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_DEPTH_W:0]   tx_count;
  logic                  tx_accept, tx_push, tx_pop, dst_ok;
  tx_state_t             state_q, state_nxt;

  assign tx_ready_o = (tx_count != TX_FULL_CNT);
  assign tx_accept  = tx_valid_i & tx_ready_o;
  assign dst_ok     = ({1'b0, tx_dst_row_i} < ROW_LIM) && ({1'b0, tx_dst_col_i} < COL_LIM);
  // Out-of-range destinations complete the handshake but never enter the FIFO.
  assign tx_push    = tx_accept & dst_ok;

  always_comb begin
    tx_pop    = 1'b0;
    state_nxt = IDLE;
    if ((tx_count != '0) && !noc_full_i) begin
      tx_pop    = 1'b1;
      state_nxt = SEND;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_count   <= '0;
      noc_pckt_o <= '0;
      tx_cnt_o   <= '0;
    end else begin
      state_q <= state_nxt;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop) begin
        tx_rd_ptr  <= tx_rd_ptr + 1'b1;
        noc_pckt_o <= tx_mem[tx_rd_ptr];
        tx_cnt_o   <= tx_cnt_o + 1'b1;
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= {tx_dst_col_i, tx_dst_row_i, tx_data_i};
  end

  assign noc_wren_o = (state_q == SEND);

  // RX path
  logic [PCKT_DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RX_DEPTH_W-1:0]  rx_wr_ptr, rx_rd_ptr;
  logic [RX_DEPTH_W:0]    rx_count, rx_count_nxt;
  logic                   rx_push, rx_pop, rx_drop, misroute;

  // Fullness is judged on pre-edge occupancy, so a same-cycle pop never rescues a push.
  assign rx_push    = noc_wren_i & ~rx_full_o;
  assign rx_drop    = noc_wren_i &  rx_full_o;
  assign rx_valid_o = (rx_count != '0);
  assign rx_pop     = rx_valid_o & rx_ready_i;
  assign rx_data_o  = rx_mem[rx_rd_ptr];
  assign misroute   = (noc_pckt_i[PACKET_W-1 -: COL_ADDR_W] != OWN_COL) ||
                      (noc_pckt_i[PCKT_DATA_W +: ROW_ADDR_W] != OWN_ROW);

  always_comb begin
    rx_count_nxt = rx_count;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_nxt = rx_count + 1'b1;
      2'b01:   rx_count_nxt = rx_count - 1'b1;
      default: rx_count_nxt = rx_count;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      rx_full_o   <= 1'b0;
      rx_ovrflw_o <= 1'b0;
      rx_cnt_o    <= '0;
      err_o       <= '0;
    end else begin
      rx_count  <= rx_count_nxt;
      rx_full_o <= (rx_count_nxt == RX_FULL_CNT);
      if (rx_push) begin
        rx_wr_ptr <= rx_wr_ptr + 1'b1;
        rx_cnt_o  <= rx_cnt_o + 1'b1;
        if (misroute) err_o[2] <= 1'b1;
      end
      if (rx_pop) rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rx_drop) begin
        rx_ovrflw_o <= 1'b1;
        err_o[1]    <= 1'b1;
      end
      if (noc_ovrflw_i) err_o[0] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= noc_pckt_i[PCKT_DATA_W-1:0];
  end

endmodule

// File: tb/tb_mesh_rsc_ni.sv
// Directed bench for mesh_rsc_ni at node (0,0) of a 3x3 mesh; inputs change and
// outputs are sampled on the falling clock edge.
module tb_mesh_rsc_ni;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [1:0]  tx_dst_row_i, tx_dst_col_i;
  logic [7:0]  tx_data_i;
  logic [11:0] noc_pckt_o;
  logic        noc_wren_o;
  logic        noc_full_i, noc_ovrflw_i;
  logic [11:0] noc_pckt_i;
  logic        noc_wren_i;
  logic        rx_full_o, rx_ovrflw_o, rx_valid_o, rx_ready_i;
  logic [7:0]  rx_data_o;
  logic [7:0]  tx_cnt_o, rx_cnt_o;
  logic [2:0]  err_o;

  int tests = 0;
  int fails = 0;

  mesh_rsc_ni dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .tx_dst_row_i(tx_dst_row_i), .tx_dst_col_i(tx_dst_col_i), .tx_data_i(tx_data_i),
    .noc_pckt_o(noc_pckt_o), .noc_wren_o(noc_wren_o),
    .noc_full_i(noc_full_i), .noc_ovrflw_i(noc_ovrflw_i),
    .noc_pckt_i(noc_pckt_i), .noc_wren_i(noc_wren_i),
    .rx_full_o(rx_full_o), .rx_ovrflw_o(rx_ovrflw_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
    .tx_cnt_o(tx_cnt_o), .rx_cnt_o(rx_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic drive_tx(input logic [1:0] row, input logic [1:0] col, input logic [7:0] data);
    tx_valid_i   = 1'b1;
    tx_dst_row_i = row;
    tx_dst_col_i = col;
    tx_data_i    = data;
  endtask

  logic [11:0] exp_pckt [4];
  logic        seen;

  initial begin
    rst_i = 1'b1;
    tx_valid_i = 1'b0; tx_dst_row_i = '0; tx_dst_col_i = '0; tx_data_i = '0;
    noc_full_i = 1'b0; noc_ovrflw_i = 1'b0; noc_pckt_i = '0; noc_wren_i = 1'b0;
    rx_ready_i = 1'b0;
    exp_pckt[0] = 12'h411; exp_pckt[1] = 12'h922;
    exp_pckt[2] = 12'h233; exp_pckt[3] = 12'h544;
    step(); step();
    check("rst_tx_ready", tx_ready_o, 1);
    check("rst_wren", noc_wren_o, 0);
    check("rst_rx_valid", rx_valid_o, 0);
    check("rst_err", err_o, 0);
    rst_i = 1'b0;
    step();

    // single TX: (2,1) 0xA5
    drive_tx(2'd2, 2'd1, 8'hA5);
    step();
    tx_valid_i = 1'b0;
    check("t1_wren_n1", noc_wren_o, 0);
    step();
    check("t1_wren_n2", noc_wren_o, 1);
    check("t1_pckt", noc_pckt_o, 12'h6A5);
    check("t1_tx_cnt", tx_cnt_o, 1);
    step();
    check("t1_wren_pulse", noc_wren_o, 0);
    check("t1_pckt_hold", noc_pckt_o, 12'h6A5);

    // invalid destinations: row 3, then col 3
    drive_tx(2'd3, 2'd0, 8'h99);
    step();
    drive_tx(2'd0, 2'd3, 8'h98);
    step();
    tx_valid_i = 1'b0;
    check("t5_tx_ready", tx_ready_o, 1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= noc_wren_o;
      step();
    end
    check("t5_no_wren", seen, 0);
    check("t5_tx_cnt", tx_cnt_o, 1);
    check("t5_err", err_o, 0);

    // backpressure: fill 4 under noc_full, then drain back-to-back
    noc_full_i = 1'b1;
    drive_tx(2'd0, 2'd1, 8'h11); step();
    drive_tx(2'd1, 2'd2, 8'h22); step();
    drive_tx(2'd2, 2'd0, 8'h33); step();
    drive_tx(2'd1, 2'd1, 8'h44); step();
    tx_valid_i = 1'b0;
    check("t2_tx_ready_full", tx_ready_o, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      noc_ovrflw_i = (i == 3);
      seen |= noc_wren_o;
      step();
    end
    noc_ovrflw_i = 1'b0;
    check("t2_stall_no_wren", seen, 0);
    check("t2_err_ovrflw", err_o, 3'b001);
    noc_full_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t2_wren_%0d", i), noc_wren_o, 1);
      check($sformatf("t2_pckt_%0d", i), noc_pckt_o, exp_pckt[i]);
    end
    check("t2_tx_ready_after", tx_ready_o, 1);
    step();
    check("t2_wren_end", noc_wren_o, 0);
    check("t2_tx_cnt", tx_cnt_o, 5);

    // RX overflow: 5 writes into depth-4 FIFO with no reader
    for (int i = 0; i < 5; i++) begin
      noc_wren_i = 1'b1;
      noc_pckt_i = {4'h0, 8'h10 + 8'(i)};
      step();
      if (i == 3) begin
        check("t3_full_after4", rx_full_o, 1);
        check("t3_no_ovrflw_yet", rx_ovrflw_o, 0);
      end
    end
    noc_wren_i = 1'b0;
    check("t3_ovrflw", rx_ovrflw_o, 1);
    check("t3_rx_cnt", rx_cnt_o, 4);
    check("t3_err", err_o, 3'b011);
    check("t3_head", rx_data_o, 8'h10);
    // push + pop while full: pop frees space, push still dropped
    noc_wren_i = 1'b1;
    noc_pckt_i = 12'h015;
    rx_ready_i = 1'b1;
    step();
    noc_wren_i = 1'b0;
    check("t3_pp_rx_cnt", rx_cnt_o, 4);
    check("t3_pp_not_full", rx_full_o, 0);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("t3_valid_%0d", i), rx_valid_o, 1);
      check($sformatf("t3_data_%0d", i), rx_data_o, 8'h10 + 8'(i));
      step();
    end
    check("t3_drained", rx_valid_o, 0);
    rx_ready_i = 1'b0;

    // misroute: row 1, col 1 at node (0,0)
    noc_wren_i = 1'b1;
    noc_pckt_i = 12'h55A;
    step();
    noc_wren_i = 1'b0;
    check("t4_valid", rx_valid_o, 1);
    check("t4_data", rx_data_o, 8'h5A);
    check("t4_err", err_o, 3'b111);
    check("t4_rx_cnt", rx_cnt_o, 5);

    // reset in the middle of a burst
    drive_tx(2'd0, 2'd0, 8'h77); step();
    drive_tx(2'd0, 2'd0, 8'h78); step();
    tx_valid_i = 1'b0;
    check("t6_in_send", noc_wren_o, 1);
    rst_i = 1'b1;
    #1;
    check("t6_wren", noc_wren_o, 0);
    check("t6_tx_cnt", tx_cnt_o, 0);
    check("t6_rx_cnt", rx_cnt_o, 0);
    check("t6_tx_ready", tx_ready_o, 1);
    check("t6_err", err_o, 0);
    check("t6_ovrflw", rx_ovrflw_o, 0);
    check("t6_rx_valid", rx_valid_o, 0);
    step(); step();
    rst_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen |= noc_wren_o;
    end
    check("t6_lost_inflight", seen, 0);
    check("t6_tx_cnt_after", tx_cnt_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
